// File: rtl/multi_consumer.sv
// Fixed-tap delay line: 7 registered stages, taps at depths 1, 2, 4 and 7.
// Optional feature macro: MULTI_CONSUMER_STALL_EN adds stall_i to freeze the whole pipeline.
module multi_consumer #(
   parameter int WIDTH = 16
) (
   input  logic             clock_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_in_i,
`ifdef MULTI_CONSUMER_STALL_EN
   input  logic             stall_i,
`endif
   output logic [WIDTH-1:0] d_out_1_o,
   output logic [WIDTH-1:0] d_out_2_o,
   output logic [WIDTH-1:0] d_out_4_o,
   output logic [WIDTH-1:0] d_out_7_o,
   output logic             rdy_o
);

   logic [7:1][WIDTH-1:0] stage_q, stage_d;
   logic                  rdy_q, rdy_d;
   logic                  shift;

`ifdef MULTI_CONSUMER_STALL_EN
   assign shift = ~stall_i;
`else
   assign shift = 1'b1;
`endif

   // Stage 1 takes d_in, every other stage takes its predecessor.
   always_comb begin
      stage_d = stage_q;
      rdy_d   = rdy_q;
      if (shift) begin
         stage_d = {stage_q[6:1], d_in_i};
         rdy_d   = 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!rst_i) begin
         stage_q <= '0;
         rdy_q   <= 1'b0;
      end else begin
         stage_q <= stage_d;
         rdy_q   <= rdy_d;
      end
   end

   assign d_out_1_o = stage_q[1];
   assign d_out_2_o = stage_q[2];
   assign d_out_4_o = stage_q[4];
   assign d_out_7_o = stage_q[7];
   assign rdy_o     = rdy_q;

endmodule

// File: tb/tb_multi_consumer.sv
// Scoreboard bench for multi_consumer: a history-queue model predicts every tap after each edge.
module tb_multi_consumer;

   typedef struct packed {
      logic [15:0] o1, o2, o4, o7;
      logic        rdy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] d_in = '0;
   logic        stall = 1'b0;
   logic [15:0] d1, d2, d4, d7;
   logic        rdy;

   exp_t        exp_q[$];
   logic [15:0] hist[$];   // accepted samples, newest first
   logic        rdy_m = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #10 clk = ~clk;

   multi_consumer #(.WIDTH(16)) dut (
      .clock_i   (clk),
      .rst_i     (rst),
      .d_in_i    (d_in),
`ifdef MULTI_CONSUMER_STALL_EN
      .stall_i   (stall),
`endif
      .d_out_1_o (d1),
      .d_out_2_o (d2),
      .d_out_4_o (d4),
      .d_out_7_o (d7),
      .rdy_o     (rdy)
   );

   function automatic logic [15:0] tap(int n);
      if (hist.size() >= n) return hist[n-1];
      return 16'h0000;
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // One clock edge: apply inputs, update the model from what the edge should do, queue the prediction.
   task automatic step(input logic r, input logic [15:0] d, input logic s);
      exp_t e;
      rst   = r;
      d_in  = d;
      stall = s;
      @(posedge clk);
`ifndef MULTI_CONSUMER_STALL_EN
      s = 1'b0;
`endif
      if (!r) begin
         hist.delete();
         rdy_m = 1'b0;
      end else if (!s) begin
         hist.push_front(d);
         if (hist.size() > 7) void'(hist.pop_back());
         rdy_m = 1'b1;
      end
      e.o1 = tap(1); e.o2 = tap(2); e.o4 = tap(4); e.o7 = tap(7); e.rdy = rdy_m;
      exp_q.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("d_out_1", d1, e.o1);
         chk("d_out_2", d2, e.o2);
         chk("d_out_4", d4, e.o4);
         chk("d_out_7", d7, e.o7);
         chk("rdy", {15'd0, rdy}, {15'd0, e.rdy});
      end
   end

   initial begin
      #1;
      // reset with d_in all ones
      step(1'b0, 16'hFFFF, 1'b0);
      step(1'b0, 16'hFFFF, 1'b0);
      // release, idle zeros
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0000, 1'b0);
      // impulse
      step(1'b1, 16'hFFFF, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 16'h0000, 1'b0);
      // ramp 1..8 then flush
      for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
      // ramp interrupted by a single reset edge, then clean restart
      for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0);
      step(1'b0, 16'h0005, 1'b0);
      for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
`ifdef MULTI_CONSUMER_STALL_EN
      // stall mid-ramp; offered values must never appear
      for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b1);
      for (int i = 4; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
      // reset wins over stall
      step(1'b0, 16'h1234, 1'b1);
      step(1'b1, 16'h4321, 1'b1);
`endif
      // randomized traffic with occasional reset (and stall when present)
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 19) != 0), 16'($urandom), ($urandom_range(0, 5) == 0));
      for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0);
      // drain, bounded
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #15;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
